sort_frame_loader: RTL and testbench
====================================

# sort_frame_loader

Upstream feeder for the serial sorter. It accepts one frame of M words over a valid/ready handshake and buffers it. It then replays the frame to the sorter as a burst of exactly M consecutive `load_enable` cycles with a stable sort direction. It holds the sorter idle long enough for sorting and output streaming, and keeps the sorter in reset between frames.

## Interface
Parameters:
- `M`, default 15: words per frame; must match the sorter's row count; M ≥ 2.
- `N`, default 8: word width; must match the sorter's column width.
- `WAIT_CYC`, default 2*M+2 (32): cycles held after the load burst for the sorter to sort and stream out; ≥ 1.
- `FC_W`, default 16: width of `frame_count`.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_data` in N: upstream word.
- `in_order` in 1: sort direction (0 = ascending, 1 = descending); sampled only with word 0 of a frame.
- `sort_rst` out 1: drives the sorter's `reset`.
- `load_enable` out 1: drives the sorter's `load_enable`.
- `data_in` out N: drives the sorter's `data_in`.
- `sortType` out 1: drives the sorter's `sortType`.
- `busy` out 1: high in LOAD and WAIT.
- `frame_done` out 1: one-cycle pulse at the end of WAIT.
- `frame_count` out FC_W: frames completed; wraps modulo 2^FC_W.

## Operation
- Storage:
  - buffer `buf[0..M-1]` of N bits;
  - `wr_ptr` and `rd_ptr`, each clog2(M+1) bits;
  - `wait_cnt`, clog2(WAIT_CYC+1) bits;
  - `state`, `sortType` and `frame_count` registers.
- States are FILL, LOAD and WAIT. Reset puts the block in FILL with `wr_ptr = rd_ptr = wait_cnt = 0`, `sortType = 0` and `frame_count = 0`.
- FILL:
  - `in_ready = 1` and `sort_rst = 1`.
  - An accept is `in_valid && in_ready`. On an accept, `buf[wr_ptr] <= in_data` and `wr_ptr` increments.
  - The accept with `wr_ptr == 0` also latches `sortType <= in_order`.
  - The accept with `wr_ptr == M-1` moves to LOAD, with `wr_ptr <= 0` and `rd_ptr <= 0`.
- LOAD:
  - `in_ready = 0`, `sort_rst = 0`, `load_enable = 1`, `data_in = buf[rd_ptr]`.
  - `rd_ptr` increments each cycle.
  - The cycle with `rd_ptr == M-1` moves to WAIT with `wait_cnt <= 0`.
- WAIT:
  - `in_ready = 0`, `sort_rst = 0`, `load_enable = 0`.
  - `wait_cnt` increments each cycle.
  - The cycle with `wait_cnt == WAIT_CYC-1` asserts `frame_done`, increments `frame_count` and moves to FILL.
- `sortType` is held constant from the end of FILL until the next frame's word 0 is accepted.
- `data_in`:
  - equals `buf[rd_ptr]` in every state;
  - in LOAD it is the meaningful value;
  - outside LOAD it is don't-care, but must not be X after the first frame.
- All outputs are decoded from registered state, pointers and counters only. There is no combinational path from `in_valid`, `in_data` or `in_order` to any output.
- Words are replayed in acceptance order. The block never reorders or drops words.
- `in_valid` held high outside FILL is ignored. The word stays pending upstream and is accepted in the first FILL cycle as word 0 of the next frame.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - `in_ready = 1`, `sort_rst = 1`;
  - `load_enable = 0`, `busy = 0`, `frame_done = 0`;
  - `sortType = 0`, `frame_count = 0`.
- Reset mid-LOAD or mid-WAIT:
  - the partial frame is discarded;
  - the next cycle looks exactly like the post-reset state;
  - the sorter is reset through `sort_rst` in that same cycle.
- Let T be the cycle of the M-th accept:
  - LOAD occupies cycles T+1 .. T+M;
  - WAIT occupies T+M+1 .. T+M+WAIT_CYC;
  - `frame_done` is high at T+M+WAIT_CYC;
  - `in_ready` and `sort_rst` are high again from T+M+WAIT_CYC+1.
- `sort_rst` falls in the same cycle `load_enable` rises. Because the sorter resets synchronously, the first LOAD word is captured at sorter address 0.
- Minimum frame period with back-to-back input is M + M + WAIT_CYC cycles (62 at defaults).
- The `frame_count` increment and the `frame_done` pulse fall in the same cycle. From all-ones, `frame_count` wraps to 0.

## Test plan
- Reset check: hold `reset` 3 cycles with random inputs. Require `in_ready = 1`, `sort_rst = 1`, `load_enable = 0`, `sortType = 0`, `frame_count = 0`, `busy = 0`.
- Ascending frame: 15 back-to-back words 15, 14, …, 1 with `in_order = 0`.
  - Require `load_enable` high for exactly 15 cycles starting T+1, with `data_in` = 15 .. 1 in order.
  - Require `frame_done` at T+47 and `frame_count = 1`.
  - With the sorter attached, its `data_out` must stream 1 .. 15.
- Descending frame with gaps: `in_valid` toggles every other cycle. Words are 3, 200, 7, 7, 0, 255, 9, 1, 50, 4, 4, 100, 2, 8, 6, with `in_order = 1` on word 0 and 0 thereafter.
  - Require `sortType = 1` through the frame and the replay to match acceptance order.
  - With the sorter attached, its `data_out` must be non-increasing.
- Backpressure: `in_valid` held high continuously with an incrementing counter as data.
  - Require `in_ready = 0` for all 47 LOAD+WAIT cycles.
  - Require the 16th value to become word 0 of frame 2, with no loss or duplication.
- Reset at LOAD cycle 5:
  - Require `load_enable = 0`, `sort_rst = 1`, `in_ready = 1` and `frame_count = 0` the next cycle.
  - A fresh frame of 0 .. 14 must then load and complete normally.
- Wrap: run with `FC_W = 2` for 5 frames. Require `frame_count` to read 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/sort_frame_loader.sv
// Buffers one M-word frame, replays it as an M-cycle load burst, then idles the sorter for WAIT_CYC cycles.
// Latency: burst starts the cycle after the M-th accept. in_ready is low for the whole burst and wait.
module sort_frame_loader #(
    parameter int M        = 15,
    parameter int N        = 8,
    parameter int WAIT_CYC = 2*M+2,
    parameter int FC_W     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    input  logic            in_order,
    output logic            sort_rst,
    output logic            load_enable,
    output logic [N-1:0]    data_in,
    output logic            sortType,
    output logic            busy,
    output logic            frame_done,
    output logic [FC_W-1:0] frame_count
);
    localparam int PW = $clog2(M+1);
    localparam int IW = $clog2(M);
    localparam int WW = $clog2(WAIT_CYC+1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(M-1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_CYC-1);

    typedef enum logic [1:0] {S_FILL, S_LOAD, S_WAIT} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    frame_buf [M];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [WW-1:0]   wait_cnt;
    logic            accept;

    assign accept  = in_valid && in_ready;
    assign data_in = frame_buf[rd_ptr[IW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        sort_rst    = 1'b0;
        load_enable = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (state)
            S_FILL: begin
                in_ready = 1'b1;
                sort_rst = 1'b1;
                if (accept && wr_ptr == LAST_PTR) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load_enable = 1'b1;
                busy        = 1'b1;
                if (rd_ptr == LAST_PTR) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == LAST_WAIT) begin
                    frame_done = 1'b1;
                    state_nxt  = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wait_cnt    <= '0;
            sortType    <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (wr_ptr == '0) sortType <= in_order;
                        if (wr_ptr == LAST_PTR) begin
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // rd_ptr parks at 0 after the burst so data_in stays a valid buffer entry
                    if (rd_ptr == LAST_PTR) begin
                        rd_ptr   <= '0;
                        wait_cnt <= '0;
                    end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        wait_cnt    <= '0;
                        frame_count <= frame_count + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) frame_buf[wr_ptr[IW-1:0]] <= in_data;
    end
endmodule

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader: timing-rule reference model, directed and random frames.
module tb_sort_frame_loader;
    localparam int M = 15;
    localparam int N = 8;
    localparam int W = 2*M+2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_order;
    logic         sort_rst, load_enable, sortType, busy, frame_done;
    logic [N-1:0] data_in;
    logic [15:0]  frame_count;

    logic         in_ready_w, sort_rst_w, load_enable_w, sortType_w, busy_w, frame_done_w;
    logic [N-1:0] data_in_w;
    logic [1:0]   frame_count_w;

    always #5 clk = ~clk;

    sort_frame_loader #(.M(M), .N(N), .WAIT_CYC(W), .FC_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_order(in_order), .sort_rst(sort_rst),
        .load_enable(load_enable), .data_in(data_in), .sortType(sortType),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    sort_frame_loader #(.M(M), .N(N), .WAIT_CYC(W), .FC_W(2)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_order(in_order), .sort_rst(sort_rst_w),
        .load_enable(load_enable_w), .data_in(data_in_w), .sortType(sortType_w),
        .busy(busy_w), .frame_done(frame_done_w), .frame_count(frame_count_w)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;

    // reference model: words of the filling frame, replay copy, cycle of last accept
    int q[$];
    int rep[$];
    int src[$];
    int t_last = -1;
    int frames = 0;
    bit st_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle();
        int  k;
        bit  e_load, e_busy, e_done;
        k      = (t_last >= 0) ? cyc - t_last : -1;
        e_load = (k >= 1) && (k <= M);
        e_busy = (k >= 1) && (k <= M + W);
        e_done = (k == M + W);
        if (chk_en) begin
            check("in_ready", in_ready, !e_busy);
            check("sort_rst", sort_rst, !e_busy);
            check("load_enable", load_enable, e_load);
            check("busy", busy, e_busy);
            check("frame_done", frame_done, e_done);
            check("sortType", sortType, st_exp);
            check("frame_count", frame_count, frames % 65536);
            check("frame_count_w", frame_count_w, frames % 4);
            if (e_load) check("data_in", data_in, rep[k-1]);
        end
        if (reset) begin
            q.delete();
            t_last = -1;
            frames = 0;
            st_exp = 0;
        end else begin
            if (e_done) begin
                frames++;
                t_last = -1;
            end
            if (!e_busy && in_valid) begin
                if (q.size() == 0) st_exp = in_order;
                q.push_back(int'(in_data));
                if (q.size() == M) begin
                    rep = q;
                    q.delete();
                    t_last = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: valid always high, 1: valid on alternate cycles, 2: random valid and order
    task automatic send(input int mode, input bit order0);
        int i = 0;
        int n = 0;
        while (i < src.size() && n < 2000) begin
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = cyc[0];
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data  = N'(src[i]);
            in_order = (mode == 2) ? 1'($urandom_range(0, 1)) : ((i % M == 0) ? order0 : 1'b0);
            if (in_valid && in_ready) begin
                cycle();
                i++;
            end else begin
                cycle();
            end
            n++;
        end
        in_valid = 1'b0;
        check("send_words", i, src.size());
    endtask

    task automatic drain();
        int n = 0;
        while (t_last >= 0 && n < 200) begin
            cycle();
            n++;
        end
        check("drain_ready", in_ready, 1);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_order = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = N'($urandom);
            in_order = 1'($urandom_range(0, 1));
            cycle();
            chk_en = 1;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        cycle();

        // frame aborted by reset in its 5th load cycle
        src.delete();
        for (int i = 0; i < M; i++) src.push_back(int'($urandom_range(0, 255)));
        send(0, 1'b1);
        for (int i = 0; i < 4; i++) cycle();
        check("abort_in_load", load_enable, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("abort_load_enable", load_enable, 0);
        check("abort_sort_rst", sort_rst, 1);
        check("abort_frame_count", frame_count, 0);
        cycle();

        // fresh frame 0..14
        src.delete();
        for (int i = 0; i < M; i++) src.push_back(i);
        send(0, 1'b0);
        drain();
        check("fresh_count", frame_count, 1);

        // ascending frame 15..1
        src.delete();
        for (int i = M; i >= 1; i--) src.push_back(i);
        send(0, 1'b0);
        drain();

        // descending frame with alternating valid
        src = '{3, 200, 7, 7, 0, 255, 9, 1, 50, 4, 4, 100, 2, 8, 6};
        send(1, 1'b1);
        check("desc_sortType", sortType, 1);
        drain();

        // continuous valid across two frames: word 15 must open frame 2
        src.delete();
        for (int i = 0; i < 2*M; i++) src.push_back(i + 16);
        send(0, 1'b1);
        drain();
        check("wrap_count_w", frame_count_w, 1);

        // random frames
        for (int f = 0; f < 2; f++) begin
            src.delete();
            for (int i = 0; i < M; i++) src.push_back(int'($urandom_range(0, 255)));
            send(2, 1'b0);
            drain();
        end
        check("final_count", frame_count, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
